// File: rtl/cpu_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller_pkg
//  Description : Shared types and constants for the CPU controller: FSM
//                state encoding, opcode/op field values, vsel one-hot codes
//                and sign-extension helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_controller_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_CALC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  // Opcode field IR[15:13]
  localparam logic [2:0] c_OPC_MOV = 3'b110;
  localparam logic [2:0] c_OPC_ALU = 3'b101;

  // op field IR[12:11] for MOV
  localparam logic [1:0] c_OP_MOV_REG = 2'b00;
  localparam logic [1:0] c_OP_MOV_IMM = 2'b10;

  // op field IR[12:11] for ALU
  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_CMP = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;
  localparam logic [1:0] c_OP_MVN = 2'b11;

  // Write-back source select, one-hot
  localparam logic [3:0] c_VSEL_MDATA = 4'b1000;
  localparam logic [3:0] c_VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] c_VSEL_PC    = 4'b0010;
  localparam logic [3:0] c_VSEL_C     = 4'b0001;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Purely combinational split of the instruction register into
//                its fields, sign-extended immediates and the ALU opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import cpu_controller_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o,
  output logic [1:0]  aluop_o
);

  // Field extraction and immediates; ALUop only meaningful for ALU opcodes
  always_comb begin
    opcode_o = ir_i[15:13];
    op_o     = ir_i[12:11];
    rn_o     = ir_i[10:8];
    rd_o     = ir_i[7:5];
    sh_o     = ir_i[4:3];
    rm_o     = ir_i[2:0];
    sximm8_o = sext8(ir_i[7:0]);
    sximm5_o = sext5(ir_i[4:0]);
    aluop_o  = (ir_i[15:13] == c_OPC_ALU) ? ir_i[12:11] : 2'b00;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Instruction register plus Moore FSM sequencing the datapath
//                strobes for MOV, MVN, ADD, AND and CMP instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn, w_rd, w_rm;
  logic [1:0]  w_sh;
  logic        w_is_unary;
  logic        w_is_cmp;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .opcode_o (w_opcode),
    .op_o     (w_op),
    .rn_o     (w_rn),
    .rd_o     (w_rd),
    .sh_o     (w_sh),
    .rm_o     (w_rm),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5),
    .aluop_o  (ALUop)
  );

  // MOV reg and MVN take a single operand, so they skip GET_A and use asel=1
  assign w_is_unary = ((w_opcode == c_OPC_MOV) && (w_op == c_OP_MOV_REG)) ||
                      ((w_opcode == c_OPC_ALU) && (w_op == c_OP_MVN));
  assign w_is_cmp   = (w_opcode == c_OPC_ALU) && (w_op == c_OP_CMP);

  // The B operand never comes from the immediate path in this instruction set
  assign bsel = 1'b0;

  // IR only accepts a new word while idle, so a busy load cannot corrupt it
  assign ir_d = (load && w) ? in : ir_q;

  // State and instruction registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state selection and Moore outputs
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    shift    = 2'b00;
    vsel     = c_VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if ((w_opcode == c_OPC_MOV) && (w_op == c_OP_MOV_IMM))
          state_d = S_WRITE_IMM;
        else if (w_is_unary)
          state_d = S_GET_B;
        else if (w_opcode == c_OPC_ALU)
          state_d = S_GET_A;
        else
          state_d = S_WAIT;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        shift   = w_sh;
        state_d = S_CALC;
      end
      S_CALC: begin
        shift = w_sh;
        asel  = w_is_unary;
        if (w_is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = c_VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Self-checking bench for cpu_controller: directed instruction
//                table, hand-written corner sequences and randomized
//                instructions checked against a per-instruction phase model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load, s;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic [3:0]  vsel;
  logic        loada, loadb, asel, bsel, loadc, loads, write;

  cpu_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write)
  );

  always #5 clk = ~clk;

  // One cycle's worth of FSM-driven outputs
  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] shift;
    logic       loada, loadb, asel, bsel, loadc, loads, write;
    logic [3:0] vsel;
  } snap_t;

  typedef struct {
    logic [15:0] instr;
    int          cycles;
    logic [15:0] sx8;
    logic [15:0] sx5;
    logic [1:0]  aluop;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];

  function automatic snap_t base_snap();
    snap_t x = '0;
    x.vsel = 4'b0001;
    return x;
  endfunction

  function automatic snap_t dut_snap();
    snap_t x;
    x.w = w; x.readnum = readnum; x.writenum = writenum; x.shift = shift;
    x.loada = loada; x.loadb = loadb; x.asel = asel; x.bsel = bsel;
    x.loadc = loadc; x.loads = loads; x.write = write; x.vsel = vsel;
    return x;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_snap(input string name, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got w=%b rn=%b wn=%b sh=%b la=%b lb=%b as=%b bs=%b lc=%b ls=%b wr=%b vs=%b expected w=%b rn=%b wn=%b sh=%b la=%b lb=%b as=%b bs=%b lc=%b ls=%b wr=%b vs=%b",
               name, act.w, act.readnum, act.writenum, act.shift, act.loada, act.loadb,
               act.asel, act.bsel, act.loadc, act.loads, act.write, act.vsel,
               exp.w, exp.readnum, exp.writenum, exp.shift, exp.loada, exp.loadb,
               exp.asel, exp.bsel, exp.loadc, exp.loads, exp.write, exp.vsel);
    end
  endtask

  // Reference model: list of per-cycle outputs after s is taken, ending in idle
  function automatic void model_seq(input logic [15:0] i);
    logic [2:0] opc = i[15:13];
    logic [1:0] op  = i[12:11];
    bit mov_imm = (opc == 3'b110) && (op == 2'b10);
    bit unary   = ((opc == 3'b110) && (op == 2'b00)) || ((opc == 3'b101) && (op == 2'b11));
    bit two_op  = (opc == 3'b101) && (op != 2'b11);
    bit cmp     = (opc == 3'b101) && (op == 2'b01);
    snap_t t;
    exp_q.delete();
    exp_q.push_back(base_snap());
    if (mov_imm) begin
      t = base_snap(); t.writenum = i[10:8]; t.vsel = 4'b0100; t.write = 1'b1;
      exp_q.push_back(t);
    end else if (unary || two_op) begin
      if (two_op) begin
        t = base_snap(); t.readnum = i[10:8]; t.loada = 1'b1;
        exp_q.push_back(t);
      end
      t = base_snap(); t.readnum = i[2:0]; t.loadb = 1'b1; t.shift = i[4:3];
      exp_q.push_back(t);
      t = base_snap(); t.shift = i[4:3]; t.asel = unary;
      if (cmp) t.loads = 1'b1; else t.loadc = 1'b1;
      exp_q.push_back(t);
      if (!cmp) begin
        t = base_snap(); t.writenum = i[7:5]; t.write = 1'b1;
        exp_q.push_back(t);
      end
    end
    t = base_snap(); t.w = 1'b1;
    exp_q.push_back(t);
  endfunction

  function automatic logic [15:0] model_sx8(input logic [15:0] i);
    logic signed [15:0] v = $signed(i[7:0]);
    return v;
  endfunction

  function automatic logic [15:0] model_sx5(input logic [15:0] i);
    logic signed [15:0] v = $signed(i[4:0]);
    return v;
  endfunction

  function automatic logic [15:0] model_aluop(input logic [15:0] i);
    return (i[15:13] == 3'b101) ? {14'b0, i[12:11]} : 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load, start, and follow one instruction; optionally toggle load/in/s while busy
  task automatic run_instr(input logic [15:0] instr, input int exp_cycles, input bit noisy);
    int busy = 0;
    load = 1'b1; in = instr; step(); load = 1'b0;
    check16("sximm8", sximm8, model_sx8(instr));
    check16("sximm5", sximm5, model_sx5(instr));
    check16("ALUop", {14'b0, ALUop}, model_aluop(instr));
    model_seq(instr);
    s = 1'b1; step(); s = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_snap($sformatf("seq %h phase %0d", instr, k), dut_snap(), exp_q[k]);
      if (!w) busy++;
      if (k < exp_q.size() - 1) begin
        if (noisy) begin
          load = 1'($urandom); s = 1'($urandom); in = 16'($urandom);
        end
        step();
      end
    end
    load = 1'b0; s = 1'b0; in = instr;
    if (noisy) check16("IR held while busy", sximm8, model_sx8(instr));
    if (exp_cycles > 0) check16($sformatf("cycles %h", instr), 16'(busy + 1), 16'(exp_cycles));
  endtask

  vec_t vecs[8];
  snap_t idle;

  initial begin
    vecs[0] = '{16'hD205, 3, 16'h0005, 16'h0005, 2'b00}; // MOV R2,#5
    vecs[1] = '{16'hD1FB, 3, 16'hFFFB, 16'hFFFB, 2'b00}; // MOV R1,#-5
    vecs[2] = '{16'hA0A1, 6, 16'hFFA1, 16'h0001, 2'b00}; // ADD R5,R0,R1
    vecs[3] = '{16'hA801, 5, 16'h0001, 16'h0001, 2'b01}; // CMP R0,R1
    vecs[4] = '{16'hC0A9, 5, 16'hFFA9, 16'h0009, 2'b00}; // MOV R5,R1,LSL#1
    vecs[5] = '{16'hE000, 2, 16'h0000, 16'h0000, 2'b00}; // illegal
    vecs[6] = '{16'hB8A3, 5, 16'hFFA3, 16'h0003, 2'b11}; // MVN R5,R3
    vecs[7] = '{16'hB0A1, 6, 16'hFFA1, 16'h0001, 2'b10}; // AND R5,R0,R1

    idle = base_snap(); idle.w = 1'b1;

    // Reset state
    rst_n = 1'b0; in = 16'h0; load = 1'b0; s = 1'b0;
    step(); step();
    check_snap("reset outputs", dut_snap(), idle);
    check16("reset IR sximm8", sximm8, 16'h0000);
    check16("reset ALUop", {14'b0, ALUop}, 16'h0000);
    rst_n = 1'b1;
    step();

    // Directed table
    for (int v = 0; v < 8; v++) begin
      run_instr(vecs[v].instr, vecs[v].cycles, 1'b0);
      check16($sformatf("tbl sx8 %h", vecs[v].instr), sximm8, vecs[v].sx8);
      check16($sformatf("tbl sx5 %h", vecs[v].instr), sximm5, vecs[v].sx5);
      check16($sformatf("tbl aluop %h", vecs[v].instr), {14'b0, ALUop}, {14'b0, vecs[v].aluop});
    end

    // load and s together: DECODE must see the new IR
    in = 16'hD205; load = 1'b1; s = 1'b1; step(); load = 1'b0; s = 1'b0;
    check16("load+s DECODE w", {15'b0, w}, 16'h0000);
    step();
    check16("load+s writenum", {13'b0, writenum}, 16'h0002);
    check16("load+s write/vsel", {11'b0, write, vsel}, {11'b0, 1'b1, 4'b0100});
    step();
    check16("load+s back to WAIT", {15'b0, w}, 16'h0001);

    // Asynchronous reset in the middle of GET_B
    in = 16'hA0A1; load = 1'b1; step(); load = 1'b0;
    s = 1'b1; step(); s = 1'b0;
    step(); step();
    check16("GET_B loadb", {12'b0, loadb, readnum}, {12'b0, 1'b1, 3'b001});
    #2 rst_n = 1'b0;
    #1;
    check_snap("async reset outputs", dut_snap(), idle);
    check16("async reset IR", sximm8, 16'h0000);
    #3 rst_n = 1'b1;
    s = 1'b1; step(); s = 1'b0;
    check16("first s after reset", {15'b0, w}, 16'h0000);
    step();
    check_snap("illegal IR back to WAIT", dut_snap(), idle);

    // s held high restarts immediately on return to WAIT
    in = 16'hD205; load = 1'b1; step(); load = 1'b0;
    s = 1'b1; step(); step(); step();
    check16("s held: WAIT", {15'b0, w}, 16'h0001);
    step();
    check16("s held: restart", {15'b0, w}, 16'h0000);
    s = 1'b0; step(); step();
    check16("s held: done", {15'b0, w}, 16'h0001);

    // Randomized instructions, half of them with load/s noise while busy
    for (int r = 0; r < 40; r++) begin
      int sel = $urandom_range(0, 3);
      logic [2:0] opc = (sel == 0) ? 3'b110 : (sel == 1) ? 3'b101 : 3'($urandom);
      run_instr({opc, 13'($urandom)}, -1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port in, input, 16 bits: instruction word.
REQ-004 The module SHALL have port load, input, 1 bit: captures in into the instruction register (IR).
REQ-005 The module SHALL have port s, input, 1 bit: start execution of the IR contents.
REQ-006 The module SHALL have port w, output, 1 bit: 1 = idle in WAIT.
REQ-007 The module SHALL have ports readnum and writenum, outputs, 3 bits each: register-file addresses.
REQ-008 The module SHALL have ports shift and ALUop, outputs, 2 bits each.
REQ-009 The module SHALL have ports sximm8 and sximm5, outputs, 16 bits each: sign-extended immediates.
REQ-010 The module SHALL have port vsel, output, 4 bits, one-hot: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C.
REQ-011 The module SHALL have outputs loada, loadb, asel, bsel, loadc, loads and write, 1 bit each: datapath strobes.

Function
REQ-012 The IR SHALL load in on a clk edge when load=1 and w=1; load SHALL be ignored while w=0.
REQ-013 IR fields SHALL be: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0], imm5 [4:0].
REQ-014 sximm8 SHALL equal sign-extend(IR[7:0]), and sximm5 SHALL equal sign-extend(IR[4:0]); both are combinational from the IR.
REQ-015 When opcode=101, ALUop SHALL equal op; otherwise ALUop SHALL be 00. shift SHALL equal IR[4:3] in the GET_B and CALC states and 00 in all other states.
REQ-016 The FSM states SHALL be WAIT, DECODE, GET_A, GET_B, CALC, WRITE_REG and WRITE_IMM, with Moore outputs.
REQ-017 From WAIT, s=1 SHALL move the FSM to DECODE; otherwise it SHALL stay in WAIT. w=1 only in WAIT.
REQ-018 From DECODE, the next state SHALL be selected as follows:
  - opcode/op 110/10 -> WRITE_IMM
  - 110/00 or 101/11 -> GET_B
  - 101/00, 101/01 or 101/10 -> GET_A
  - any other encoding -> WAIT, with no strobes asserted
REQ-019 GET_A SHALL drive readnum=Rn and loada=1, then go to GET_B.
REQ-020 GET_B SHALL drive readnum=Rm and loadb=1, then go to CALC.
REQ-021 CALC SHALL drive asel=1 for 110/00 and 101/11, and asel=0 otherwise.
  - For 101/01 (CMP): loads=1 and loadc=0, next state WAIT.
  - Otherwise: loadc=1, next state WRITE_REG.
REQ-022 WRITE_REG SHALL drive writenum=Rd, vsel=0001 and write=1, then go to WAIT.
REQ-023 WRITE_IMM SHALL drive writenum=Rn, vsel=0100 and write=1, then go to WAIT.
REQ-024 In every state, strobes not named for that state SHALL be 0, readnum/writenum not named SHALL be 000, vsel not named SHALL be 0001, and bsel SHALL always be 0.
REQ-025 Cycle counts, from the edge where s is sampled high to the return to WAIT, SHALL be:
  - MOV imm: 3 cycles
  - MOV reg / MVN: 5 cycles
  - ADD / AND: 6 cycles
  - CMP: 5 cycles
REQ-026 s=1 and load=1 sampled together in WAIT SHALL load the IR and enter DECODE on the same edge; DECODE SHALL use the new IR value.
REQ-027 s asserted outside WAIT SHALL be ignored. s held high SHALL start a new instruction on the first cycle back in WAIT.

Reset
REQ-028 rst_n=0 SHALL immediately force state=WAIT, IR=0x0000, w=1, all strobes 0, readnum=writenum=000 and vsel=0001, in any state including mid-instruction.
REQ-029 The first s sampled after rst_n rises SHALL be honoured normally.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the opcode/op constants (MOV=110, ALU=101, op codes) and the vsel one-hot constants.
REQ-031 A combinational sub-module instr_decoder SHALL split the IR into fields, the sign-extended immediates and ALUop; the FSM and IR SHALL live in cpu_controller.

Verification
REQ-032 Load 0xD205 (MOV R2,#5) and pulse s: WRITE_IMM shows writenum=010, vsel=0100, write=1, sximm8=0x0005, and w=1 three cycles after s.
REQ-033 Load 0xD1FB (MOV R1,#-5): sximm8=0xFFFB.
REQ-034 Load 0xA0A1 (ADD R5,R0,R1): observe the sequence
  - loada with readnum=000
  - loadb with readnum=001
  - loadc with asel=0, ALUop=00
  - write with writenum=101, vsel=0001
REQ-035 Load 0xA801 (CMP R0,R1): CALC asserts loads=1 and loadc=0, and no write occurs; w returns after 5 cycles.
REQ-036 Load 0xC0A9 (MOV R5,R1,LSL#1): GET_A is skipped; CALC shows asel=1 and shift=01; then write with writenum=101.
REQ-037 Start ADD and drop rst_n during GET_B: state=WAIT and loadb=0 without waiting for clk. A load pulse while busy leaves the IR unchanged; the illegal word 0xE000 returns to WAIT with no write.
